// File: rtl/regs_pkg.sv
// Shared definitions for the picoMIPS register file and its write-port arbiter.
package regs_pkg;
  localparam int N_REGS     = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_IO  = 1'b1
  } wr_src_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant. The last_grant register is the only state and is
// exposed directly so checkers can observe it.
module rr_arb2
  import regs_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       hold,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  output wr_src_t    last_grant
);

  // Handshake: a transfer from requester i happens on a clock edge where
  // req_valid[i] & req_ready[i]. Ready depends only on valid, hold, reset and
  // last_grant, never on the write-port outputs. On a tie the requester not
  // named by last_grant wins.
  always_comb begin
    req_ready = 2'b00;
    if (!reset && !hold) begin
      req_ready[0] = req_valid[0] & (!req_valid[1] | (last_grant == REQ_IO));
      req_ready[1] = req_valid[1] & (!req_valid[0] | (last_grant == REQ_ALU));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= REQ_IO;
    end else if (req_ready[1]) begin
      last_grant <= REQ_IO;
    end else if (req_ready[0]) begin
      last_grant <= REQ_ALU;
    end
  end

endmodule

// File: rtl/regs_wr_arb.sv
// Write-port arbiter: registers the winning writeback request onto the register
// file's write port and drops (and counts) writes aimed at %0.
module regs_wr_arb
  import regs_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         hold,
  input  logic [1:0]   req_valid,
  input  logic [4:0]   req_rd0,
  input  logic [4:0]   req_rd1,
  input  logic [n-1:0] req_data0,
  input  logic [n-1:0] req_data1,
  output logic [1:0]   req_ready,
  output logic         w,
  output logic [4:0]   w_rd,
  output logic [n-1:0] w_data,
  output logic         last_grant,
  output logic [7:0]   drop_cnt
);

  wr_src_t   grant_state;
  logic      xfer;
  reg_addr_t sel_rd;
  logic [n-1:0] sel_data;

  rr_arb2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .hold       (hold),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .last_grant (grant_state)
  );

  assign last_grant = grant_state;
  assign xfer       = |req_ready;

  // At most one ready bit is set, so ready[1] alone selects the winner.
  always_comb begin
    sel_rd   = req_ready[1] ? req_rd1   : req_rd0;
    sel_data = req_ready[1] ? req_data1 : req_data0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w        <= 1'b0;
      w_rd     <= '0;
      w_data   <= '0;
      drop_cnt <= '0;
    end else begin
      w <= 1'b0;
      if (xfer) begin
        if (sel_rd != ZERO_REG) begin
          w      <= 1'b1;
          w_rd   <= sel_rd;
          w_data <= sel_data;
        end else if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_regs_wr_arb.sv
// Directed bench for regs_wr_arb: reset, single write, contention, hold,
// %0 drop with saturation, and reset in the middle of a burst.
module tb_regs_wr_arb;
  localparam int n = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         hold;
  logic [1:0]   req_valid;
  logic [4:0]   req_rd0, req_rd1;
  logic [n-1:0] req_data0, req_data1;
  logic [1:0]   req_ready;
  logic         w;
  logic [4:0]   w_rd;
  logic [n-1:0] w_data;
  logic         last_grant;
  logic [7:0]   drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  regs_wr_arb #(.n(n)) dut (
    .clk        (clk),
    .reset      (reset),
    .hold       (hold),
    .req_valid  (req_valid),
    .req_rd0    (req_rd0),
    .req_rd1    (req_rd1),
    .req_data0  (req_data0),
    .req_data1  (req_data1),
    .req_ready  (req_ready),
    .w          (w),
    .w_rd       (w_rd),
    .w_data     (w_data),
    .last_grant (last_grant),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  // Advance past the next active edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_port(input string tag, input logic [4:0] rd, input logic [7:0] data);
    chk({tag, "_w"}, 32'(w), 32'd1);
    chk({tag, "_w_rd"}, 32'(w_rd), 32'(rd));
    chk({tag, "_w_data"}, 32'(w_data), 32'(data));
  endtask

  logic [1:0] exp_ready [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [4:0] exp_rd    [4] = '{5'd3, 5'd4, 5'd3, 5'd4};
  logic [7:0] exp_data  [4] = '{8'h11, 8'h22, 8'h11, 8'h22};

  initial begin
    int exp_drop;
    reset = 1'b1; hold = 1'b0; req_valid = 2'b00;
    req_rd0 = '0; req_rd1 = '0; req_data0 = '0; req_data1 = '0;

    // Reset then idle; a request during reset is not granted
    tick();
    req_valid = 2'b01; req_rd0 = 5'd9; req_data0 = 8'h99;
    #1 chk("ready_in_reset", 32'(req_ready), 32'd0);
    tick();
    reset = 1'b0; req_valid = 2'b00;
    #1;
    chk("rst_w", 32'(w), 32'd0);
    chk("rst_w_rd", 32'(w_rd), 32'd0);
    chk("rst_w_data", 32'(w_data), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_last_grant", 32'(last_grant), 32'd1);
    chk("rst_ready", 32'(req_ready), 32'd0);

    // Single write from requester 0
    req_valid = 2'b01; req_rd0 = 5'd5; req_data0 = 8'hA5;
    #1 chk("single_ready", 32'(req_ready), 32'b01);
    tick();
    req_valid = 2'b00;
    chk_port("single", 5'd5, 8'hA5);
    chk("single_last_grant", 32'(last_grant), 32'd0);
    tick();
    chk("single_w_after", 32'(w), 32'd0);
    chk("single_w_rd_hold", 32'(w_rd), 32'd5);

    // Re-reset so requester 0 wins the first tie
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Contention: both valid every cycle
    req_valid = 2'b11;
    req_rd0 = 5'd3; req_data0 = 8'h11;
    req_rd1 = 5'd4; req_data1 = 8'h22;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("cont_ready%0d", i), 32'(req_ready), 32'(exp_ready[i]));
      tick();
      chk_port($sformatf("cont%0d", i), exp_rd[i], exp_data[i]);
    end
    chk("cont_last_grant", 32'(last_grant), 32'd1);

    // Hold blocks all grants; release lets requester 0 win immediately
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("hold_ready%0d", i), 32'(req_ready), 32'd0);
      tick();
      chk($sformatf("hold_w%0d", i), 32'(w), 32'd0);
    end
    hold = 1'b0;
    #1 chk("release_ready", 32'(req_ready), 32'b01);
    tick();
    req_valid = 2'b00;
    chk_port("release", 5'd3, 8'h11);
    chk("release_last_grant", 32'(last_grant), 32'd0);

    // Writes to %0 are accepted but dropped; counter saturates
    req_valid = 2'b10; req_rd1 = 5'd0; req_data1 = 8'hFF;
    exp_drop = 0;
    for (int i = 0; i < 300; i++) begin
      #1 chk("drop_ready", 32'(req_ready), 32'b10);
      tick();
      exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
      chk("drop_w", 32'(w), 32'd0);
      chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    end
    chk("drop_w_rd_hold", 32'(w_rd), 32'd3);
    chk("drop_w_data_hold", 32'(w_data), 32'h11);
    chk("drop_final", 32'(drop_cnt), 32'd255);
    req_valid = 2'b00;
    tick();

    // Reset mid-burst
    req_valid = 2'b01; req_rd0 = 5'd7; req_data0 = 8'h77;
    #1 chk("burst_ready", 32'(req_ready), 32'b01);
    tick();
    chk_port("burst", 5'd7, 8'h77);
    reset = 1'b1;
    #1 chk("burst_ready_rst", 32'(req_ready), 32'd0);
    tick();
    reset = 1'b0;
    chk("burst_w_rst", 32'(w), 32'd0);
    chk("burst_last_grant_rst", 32'(last_grant), 32'd1);
    chk("burst_drop_rst", 32'(drop_cnt), 32'd0);
    #1 chk("burst_ready_resume", 32'(req_ready), 32'b01);
    tick();
    req_valid = 2'b00;
    chk_port("burst_resume", 5'd7, 8'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
